mgmt_wb_fabric: RTL and testbench

//  Parametrised successor to the fixed two-port (user-project / housekeeping) export of the management core bus.

---
 rtl/mgmt_wb_pkg.sv | 22 ++
 rtl/mgmt_wb_addr_decode.sv | 30 +++
 rtl/mgmt_wb_fabric.sv | 183 ++++++++++++++++++
 tb/tb_mgmt_wb_fabric.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_wb_pkg.sv
// rtl/mgmt_wb_pkg.sv - shared types, defaults and helpers for the management Wishbone fabric
package mgmt_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [31:0] MGMT_WB_ERR_DATA = 32'hDEAD_BEEF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mgmt_wb_addr_decode.sv
// rtl/mgmt_wb_addr_decode.sv - base/mask address decode with lowest-index priority select
module mgmt_wb_addr_decode
    import mgmt_wb_pkg::*;
#(
    parameter int                    NUM_SLV  = 4,
    parameter int                    AW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0,
    parameter int                    IW       = (clog2(NUM_SLV) < 1) ? 1 : clog2(NUM_SLV)
) (
    input  logic [AW-1:0]      adr_i,
    output logic [NUM_SLV-1:0] hit_o,
    output logic [IW-1:0]      sel_o,
    output logic               miss_o
);

    always_comb begin
        hit_o = '0;
        sel_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            hit_o[i] = ((adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
        end
        // Walk downwards so the lowest-index hit is the one left standing.
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit_o[i]) sel_o = IW'(i);
        end
        miss_o = ~|hit_o;
    end

endmodule

// File: rtl/mgmt_wb_fabric.sv
// rtl/mgmt_wb_fabric.sv - one-master to NUM_SLV-slave Wishbone fabric; bus timeout under MGMT_WB_TIMEOUT_EN
module mgmt_wb_fabric
    import mgmt_wb_pkg::*;
#(
    parameter int                    NUM_SLV  = 4,
    parameter int                    AW       = 32,
    parameter int                    DW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2610_0000, 32'h2600_0000, 32'h2500_0000},
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {4{32'hFF00_0000}},
    parameter int                    TO_CYC   = 255,
    parameter logic [DW-1:0]         ERR_DATA = DW'(MGMT_WB_ERR_DATA)
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    input  logic                  m_we_i,
    input  logic [DW/8-1:0]       m_sel_i,
    input  logic [AW-1:0]         m_adr_i,
    input  logic [DW-1:0]         m_dat_i,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic [DW-1:0]         m_dat_o,
    output logic [NUM_SLV-1:0]    s_cyc_o,
    output logic [NUM_SLV-1:0]    s_stb_o,
    output logic                  s_we_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    input  logic [NUM_SLV-1:0]    s_ack_i,
    input  logic [NUM_SLV*DW-1:0] s_dat_i,
    output logic [NUM_SLV-1:0]    s_iena_o,
    input  logic [NUM_SLV-1:0]    slv_en_i,
    output logic                  timeout_o,
    output logic [AW-1:0]         err_adr_o
);

    localparam int IW = (clog2(NUM_SLV) < 1) ? 1 : clog2(NUM_SLV);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [DW/8-1:0]     sel_q, sel_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       wdat_q, wdat_d;
    logic [IW-1:0]       slv_q, slv_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DW-1:0]       rdat_q, rdat_d;
    logic [AW-1:0]       err_adr_q, err_adr_d;
    logic                to_q, to_d;
    logic                tmo_hit;

    logic [NUM_SLV-1:0]  dec_hit;
    logic [IW-1:0]       dec_sel;
    logic                dec_miss;
    logic                dec_ok;
    logic [NUM_SLV-1:0]  slv_onehot;

    mgmt_wb_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .IW       (IW)
    ) u_decode (
        .adr_i  (m_adr_i),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel),
        .miss_o (dec_miss)
    );

    assign dec_ok     = !dec_miss && |(dec_hit & slv_en_i & (NUM_SLV'(1) << dec_sel));
    assign slv_onehot = NUM_SLV'(1) << slv_q;

`ifdef MGMT_WB_TIMEOUT_EN
    localparam int CW_RAW = clog2(TO_CYC + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

    logic [CW-1:0] cnt_q;

    // Count reads 0 in the first BUSY cycle, so TO_CYC-1 marks the last strobed cycle.
    always_ff @(posedge core_clk) begin
        if (core_rst || state_q != BUSY) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 1'b1;
    end

    assign tmo_hit = (cnt_q == CW'(TO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        slv_d     = slv_q;
        rdat_d    = rdat_q;
        err_adr_d = err_adr_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    we_d    = m_we_i;
                    sel_d   = m_sel_i;
                    adr_d   = m_adr_i;
                    wdat_d  = m_dat_i;
                    slv_d   = dec_sel;
                    state_d = dec_ok ? BUSY : ERR;
                end
            end
            BUSY: begin
                // Abort beats a same-cycle ack; ack beats a same-cycle timeout.
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (s_ack_i[slv_q]) begin
                    ack_d   = 1'b1;
                    rdat_d  = s_dat_i[int'(slv_q)*DW +: DW];
                    state_d = RESP;
                end else if (tmo_hit) begin
                    to_d    = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                ack_d     = 1'b1;
                err_d     = 1'b1;
                rdat_d    = ERR_DATA;
                err_adr_d = adr_q;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            slv_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            err_adr_q <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            slv_q     <= slv_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            err_adr_q <= err_adr_d;
            to_q      <= to_d;
        end
    end

    assign s_cyc_o   = (state_q == BUSY) ? slv_onehot : '0;
    assign s_stb_o   = s_cyc_o;
    assign s_iena_o  = s_cyc_o;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;
    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign m_dat_o   = rdat_q;
    assign err_adr_o = err_adr_q;
    assign timeout_o = to_q;

endmodule

// File: tb/tb_mgmt_wb_fabric.sv
// tb/tb_mgmt_wb_fabric.sv - self-checking bench for mgmt_wb_fabric against a transaction-level memory model
module tb_mgmt_wb_fabric;

    localparam int NUM_SLV = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TO_CYC  = 16;

    logic                  core_clk = 1'b0;
    logic                  core_rst;
    logic                  m_cyc_i, m_stb_i, m_we_i;
    logic [3:0]            m_sel_i;
    logic [31:0]           m_adr_i, m_dat_i;
    logic                  m_ack_o, m_err_o;
    logic [31:0]           m_dat_o;
    logic [3:0]            s_cyc_o, s_stb_o, s_iena_o;
    logic                  s_we_o;
    logic [3:0]            s_sel_o;
    logic [31:0]           s_adr_o, s_dat_o;
    logic [3:0]            s_ack_i;
    logic [127:0]          s_dat_i;
    logic [3:0]            slv_en_i;
    logic                  timeout_o;
    logic [31:0]           err_adr_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] base_a [4] = '{32'h2500_0000, 32'h2600_0000, 32'h2610_0000, 32'h3000_0000};
    logic [31:0] mask_a [4] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    mgmt_wb_fabric #(
        .NUM_SLV (NUM_SLV),
        .AW      (AW),
        .DW      (DW),
        .TO_CYC  (TO_CYC)
    ) dut (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .s_iena_o  (s_iena_o),
        .slv_en_i  (slv_en_i),
        .timeout_o (timeout_o),
        .err_adr_o (err_adr_o)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    function automatic int model_target(input logic [31:0] adr);
        for (int i = 0; i < 4; i++) begin
            if ((adr & mask_a[i]) == base_a[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] fresh(input logic [31:0] adr);
        return adr ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr;  m_dat_i = dat;  m_sel_i = sel;
    endtask

    // Bench-side slave: completes the current strobe from its own memory.
    task automatic slave_ack(input int t);
        logic [31:0] old;
        old = slv_mem.exists(s_adr_o) ? slv_mem[s_adr_o] : fresh(s_adr_o);
        if (s_we_o) slv_mem[s_adr_o] = merge(old, s_dat_o, s_sel_o);
        s_dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_dat_i[t*32 +: 32] = old;
        s_ack_i = 4'(1 << t);
    endtask

    task automatic finish_ok(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] exp_rd;
        check("ack", 32'(m_ack_o), 32'd1);
        check("ack_err", 32'(m_err_o), 32'd0);
        check("stb_drop", 32'(s_stb_o), 32'd0);
        exp_rd = ref_mem.exists(adr) ? ref_mem[adr] : fresh(adr);
        if (we) ref_mem[adr] = merge(exp_rd, dat, sel);
        else    check("rdata", m_dat_o, exp_rd);
    endtask

    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int dly, input bit spur);
        int t;
        t = model_target(adr);
        start_req(we, adr, dat, sel);
        step();
        if (t >= 0 && slv_en_i[t]) begin
            check("stb_onehot", 32'(s_stb_o), 32'(1 << t));
            check("cyc_onehot", 32'(s_cyc_o), 32'(1 << t));
            check("iena_onehot", 32'(s_iena_o), 32'(1 << t));
            check("s_adr", s_adr_o, adr);
            check("s_we", 32'(s_we_o), 32'(we));
            check("s_sel", 32'(s_sel_o), 32'(sel));
            for (int c = 0; c < dly; c++) begin
                if (spur) s_ack_i = 4'(~(1 << t));
                step();
                s_ack_i = '0;
                check("no_early_ack", 32'(m_ack_o), 32'd0);
                check("stb_held", 32'(s_stb_o), 32'(1 << t));
            end
            slave_ack(t);
            step();
            s_ack_i = '0;
            finish_ok(we, adr, dat, sel);
        end else begin
            check("err_no_cyc", 32'(s_cyc_o), 32'd0);
            check("err_no_early_ack", 32'(m_ack_o), 32'd0);
            step();
            check("err_ack", 32'(m_ack_o), 32'd1);
            check("err_flag", 32'(m_err_o), 32'd1);
            check("err_data", m_dat_o, 32'hDEAD_BEEF);
            check("err_adr", err_adr_o, adr);
            check("err_no_stb", 32'(s_stb_o), 32'd0);
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        step();
        check("ack_pulse", 32'(m_ack_o), 32'd0);
    endtask

    initial begin
        core_rst = 1'b1;
        m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_sel_i = 0; m_adr_i = 0; m_dat_i = 0;
        s_ack_i = 0; s_dat_i = 0; slv_en_i = 4'hF;
        step(); step(); step();
        check("rst_ack", 32'(m_ack_o), 32'd0);
        check("rst_err", 32'(m_err_o), 32'd0);
        check("rst_mdat", m_dat_o, 32'd0);
        check("rst_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_stb", 32'(s_stb_o), 32'd0);
        check("rst_iena", 32'(s_iena_o), 32'd0);
        check("rst_sadr", s_adr_o, 32'd0);
        check("rst_sdat", s_dat_o, 32'd0);
        check("rst_swe_sel", {27'd0, s_we_o, s_sel_o}, 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_err_adr", err_adr_o, 32'd0);
        core_rst = 1'b0;
        step();

        // Read slave 1, ack two cycles after the strobe appears.
        ref_mem[32'h2600_0010] = 32'h1234_5678;
        slv_mem[32'h2600_0010] = 32'h1234_5678;
        access(1'b0, 32'h2600_0010, 32'h0, 4'hF, 2, 1'b0);
        access(1'b1, 32'h4000_0000, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        slv_en_i = 4'b0111;
        access(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 1'b0);
        slv_en_i = 4'hF;
        access(1'b1, 32'h2500_0008, 32'hA1B2_C3D4, 4'h5, 3, 1'b1);
        access(1'b0, 32'h2500_0008, 32'h0, 4'hF, 0, 1'b1);

        // Abort with a coincident ack: no response.
        start_req(1'b0, 32'h2500_0040, 32'h0, 4'hF);
        step();
        check("abort_stb_on", 32'(s_stb_o), 32'd1);
        m_cyc_i = 0; m_stb_i = 0; s_ack_i = 4'b0001;
        step();
        s_ack_i = '0;
        check("abort_stb_off", 32'(s_stb_o), 32'd0);
        check("abort_no_ack", 32'(m_ack_o), 32'd0);
        step();
        check("abort_no_ack2", 32'(m_ack_o), 32'd0);
        access(1'b0, 32'h2500_0040, 32'h0, 4'hF, 1, 1'b0);

        // Reset in the middle of BUSY.
        start_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        step();
        check("rstb_stb_on", 32'(s_stb_o), 32'd8);
        core_rst = 1'b1;
        step();
        check("rstb_stb_off", 32'(s_stb_o), 32'd0);
        check("rstb_no_ack", 32'(m_ack_o), 32'd0);
        core_rst = 1'b0; m_cyc_i = 0; m_stb_i = 0;
        step();
        check("rstb_no_ack2", 32'(m_ack_o), 32'd0);
        access(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 1'b0);

`ifdef MGMT_WB_TIMEOUT_EN
        start_req(1'b0, 32'h2500_0080, 32'h0, 4'hF);
        for (int c = 0; c < TO_CYC; c++) begin
            step();
            check("to_stb_held", 32'(s_stb_o), 32'd1);
            check("to_not_yet", {30'd0, m_ack_o, timeout_o}, 32'd0);
        end
        step();
        check("to_pulse", 32'(timeout_o), 32'd1);
        check("to_stb_drop", 32'(s_stb_o), 32'd0);
        step();
        check("to_ack", {30'd0, m_ack_o, m_err_o}, 32'd3);
        check("to_data", m_dat_o, 32'hDEAD_BEEF);
        check("to_err_adr", err_adr_o, 32'h2500_0080);
        check("to_pulse_end", 32'(timeout_o), 32'd0);
        m_cyc_i = 0; m_stb_i = 0;
        step();
        access(1'b0, 32'h2500_0080, 32'h0, 4'hF, TO_CYC - 1, 1'b1);
        check("to_ack_wins", 32'(timeout_o), 32'd0);
`else
        access(1'b0, 32'h2500_0080, 32'h0, 4'hF, 40, 1'b0);
        check("no_timeout", 32'(timeout_o), 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [31:0] reg_base [5];
            logic [31:0] adr;
            reg_base = '{32'h2500_0000, 32'h2600_0000, 32'h2610_0000, 32'h3000_0000, 32'h4000_0000};
            adr = reg_base[$urandom_range(0, 4)] | (32'($urandom_range(0, 7)) << 2);
            slv_en_i = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : 4'hF;
            access(1'($urandom_range(0, 1)), adr, $urandom(), 4'($urandom_range(1, 15)),
                   $urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
